// File: rtl/tdm_demux_pkg.sv
// Shared constants and state type for the 16-slot TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a 17th even-parity slot to every frame.
package tdm_demux_pkg;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FRAME_LEN = N_CH + 1;
    localparam int unsigned CNT_W     = SEL_W + 1;
`else
    localparam int unsigned FRAME_LEN = N_CH;
    localparam int unsigned CNT_W     = SEL_W;
`endif

    // The final slot of a frame is consumed directly, so only the earlier ones need storage.
    localparam int unsigned SHADOW_W = FRAME_LEN - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: clear, load-to-one on frame start, advance on enable,
// terminal-count flag on the last slot of the frame.
module tdm_slot_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAST  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_one,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

    assign tc = (count == LAST_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load_one) begin
            count <= ONE_V;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// 1-to-16 TDM demultiplexer: sync-aligned serial slots into a parallel frame register.
// Optional TDM_DEMUX_PARITY_EN appends an even-parity slot checked before each transfer.
module tdm_demux16
    import tdm_demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [N_CH-1:0]  out,
    output logic             out_valid,
    output logic [CNT_W-1:0] slot,
    output logic             err,
    output logic             locked
);

    state_t              state;
    logic [SHADOW_W-1:0] shadow;
    logic                at_zero;
    logic                tc;
    logic                cnt_en;
    logic                cnt_load;
    logic                cnt_clr;

    assign at_zero = (slot == '0);

    always_comb begin
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        if (din_valid) begin
            unique case (state)
                IDLE: cnt_load = sync;
                RUN: begin
                    if (sync)         cnt_load = 1'b1;
                    else if (at_zero) cnt_clr  = 1'b1;
                    else              cnt_en   = 1'b1;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    tdm_slot_counter #(
        .WIDTH (CNT_W),
        .LAST  (FRAME_LEN - 1)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (cnt_en),
        .load_one (cnt_load),
        .clr      (cnt_clr),
        .count    (slot),
        .tc       (tc)
    );

    // A sync mid-frame takes priority over the terminal slot: the frame restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    IDLE: begin
                        if (sync) begin
                            shadow[0] <= din;
                            state     <= RUN;
                            locked    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sync) begin
                            shadow[0] <= din;
                            if (!at_zero) err <= 1'b1;
                        end else if (at_zero) begin
                            err    <= 1'b1;
                            state  <= IDLE;
                            locked <= 1'b0;
                        end else if (tc) begin
`ifdef TDM_DEMUX_PARITY_EN
                            if ((^shadow) ^ din) begin
                                err <= 1'b1;
                            end else begin
                                out       <= shadow;
                                out_valid <= 1'b1;
                            end
`else
                            out       <= {din, shadow};
                            out_valid <= 1'b1;
`endif
                        end else begin
                            shadow[slot[SEL_W-1:0]] <= din;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
